// File: rtl/if_fetch_controller_pkg.sv
// Shared constants and state encoding for the IF-stage fetch controller.
package if_fetch_controller_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam logic [ADDRESS_LEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_controller_skid.sv
// One-entry {pc, instruction} holding register; catches a fetch that lands while IF is frozen.
module fetch_skid_buffer
  import if_fetch_controller_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_LEN,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_instr,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;

  // clear wins: a redirect must never let a stale entry survive
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the imem req/ack handshake, handles
// redirect and freeze. Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request outstanding (frozen, or skid waiting to drain)
// REQ   | request outstanding on fetch_pc; data is used on ack
// DRAIN | redirect seen mid-request; finish old fetch, discard it, then go to pending
module if_fetch_controller
  import if_fetch_controller_pkg::*;
#(
  parameter int                ADDR_W         = ADDRESS_LEN,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              if_valid,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              skid_load, skid_clear, skid_valid, capture;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_instr;

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (fetch_pc_q + PC_INC),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          fetch_pc_d = branch_addr;
          state_d    = REQ;
        end else if (!freeze && !skid_valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            fetch_pc_d = branch_addr;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_INC;
            if (freeze) begin
              skid_load = 1'b1;
              state_d   = IDLE;
            end else begin
              capture = 1'b1;
            end
          end
        end else if (branch_taken) begin
          pending_d = branch_addr;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // address must stay put until the old fetch completes; newest redirect wins
        if (imem_ack) begin
          fetch_pc_d = branch_taken ? branch_addr : pending_q;
          state_d    = REQ;
        end else if (branch_taken) begin
          pending_d = branch_addr;
        end
      end
      default: state_d = IDLE;
    endcase

    if (branch_taken) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
    end else if (!freeze) begin
      if (skid_valid) begin
        pc_d       = skid_pc;
        instr_d    = skid_instr;
        valid_d    = 1'b1;
        skid_clear = 1'b1;
      end else if (capture) begin
        pc_d    = fetch_pc_q + PC_INC;
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // down-counter reloads whenever no handshake is stuck; sticky error at terminal count
  always_comb begin
    tmo_d = TMO_W'(TIMEOUT_CYCLES);
    err_d = err_q;
    if (state_q != IDLE && !imem_ack) begin
      tmo_d = tmo_q;
      if (tmo_q != '0) begin
        tmo_d = tmo_q - TMO_W'(1);
        if (tmo_q == TMO_W'(1)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= TMO_W'(TIMEOUT_CYCLES);
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign fetch_err  = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign if_valid    = valid_q;

endmodule
